// File: rtl/gate_tt_pkg.sv
// Shared encodings for the gate truth-table checker: function selects,
// checker states and vector count.
package gate_tt_pkg;

  localparam logic [2:0] FN_AND  = 3'd0;
  localparam logic [2:0] FN_NAND = 3'd1;
  localparam logic [2:0] FN_OR   = 3'd2;
  localparam logic [2:0] FN_XOR  = 3'd3;
  localparam logic [2:0] FN_NOT  = 3'd4;

  localparam int unsigned NUM_VEC = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  function automatic logic fn_is_legal(input logic [2:0] fn);
    return fn <= FN_NOT;
  endfunction

endpackage

// File: rtl/gate_tt_ref.sv
// Combinational expected-value model for the single-output lab gates.
module gate_tt_ref
  import gate_tt_pkg::*;
(
  input  logic [2:0] func,
  input  logic       a,
  input  logic       b,
  output logic       expected
);

  always_comb begin
    expected = 1'b0;
    case (func)
      FN_AND:  expected = a & b;
      FN_NAND: expected = ~(a & b);
      FN_OR:   expected = a | b;
      FN_XOR:  expected = a ^ b;
      FN_NOT:  expected = ~a;
      default: expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Walks all four input vectors onto a gate under test, samples its output
// after a settle interval and records a per-vector mismatch map.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] func_sel,
  input  logic       dut_out,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_vec,
  output logic [2:0] err_count
);

  state_e     state_q, state_d;
  logic [2:0] func_q, func_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [2:0] err_count_q, err_count_d;
  logic       pass_q, pass_d;
  logic       expected;

  gate_tt_ref u_ref (
    .func     (func_q),
    .a        (idx_q[0]),
    .b        (idx_q[1]),
    .expected (expected)
  );

  always_comb begin
    state_d     = state_q;
    func_d      = func_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fail_vec_d  = fail_vec_q;
    err_count_d = err_count_q;
    pass_d      = pass_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          func_d      = func_sel;
          fail_vec_d  = '0;
          err_count_d = '0;
          pass_d      = 1'b0;
          idx_d       = '0;
          cnt_d       = '0;
          if (fn_is_legal(func_sel)) begin
            state_d = ST_SETTLE;
          end else begin
            fail_vec_d  = '1;
            err_count_d = 3'(NUM_VEC);
            state_d     = ST_DONE;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) state_d = ST_SAMPLE;
        else                                cnt_d   = cnt_q + 4'd1;
      end
      ST_SAMPLE: begin
        if (dut_out != expected) begin
          fail_vec_d[idx_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end
        if (idx_q == 2'(NUM_VEC - 1)) begin
          // pass is taken from the post-sample count so it is valid in DONE
          pass_d  = (err_count_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      func_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fail_vec_q  <= '0;
      err_count_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      fail_vec_q  <= fail_vec_d;
      err_count_q <= err_count_d;
      pass_q      <= pass_d;
    end
  end

  assign stim_a    = idx_q[0];
  assign stim_b    = idx_q[1];
  assign busy      = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail_vec  = fail_vec_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Randomized bench: a truth-table model of the gate under test is compared
// with a truth-table model of the expected function.
module tb_gate_tt_checker;

  localparam int unsigned S = 2;
  localparam int unsigned RUN_CYC = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] func_sel;
  logic       dut_out;
  logic       stim_a, stim_b, busy, done, pass;
  logic [3:0] fail_vec;
  logic [2:0] err_count;

  // Physical gate behaviour: bit i is the output for vector {b,a}=i.
  logic [3:0] phys_tt;
  logic [1:0] vidx;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  assign vidx    = {stim_b, stim_a};
  assign dut_out = phys_tt[vidx];

  gate_tt_checker #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .func_sel  (func_sel),
    .dut_out   (dut_out),
    .stim_a    (stim_a),
    .stim_b    (stim_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_vec  (fail_vec),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected truth table of each function, bit i = output for vector {b,a}=i.
  function automatic logic [3:0] exp_tt(input logic [2:0] f);
    case (f)
      3'd0: return 4'b1000;
      3'd1: return 4'b0111;
      3'd2: return 4'b1110;
      3'd3: return 4'b0110;
      3'd4: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] popcnt(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, ".busy"}, 8'(busy), 8'd0);
    check({tag, ".done"}, 8'(done), 8'd0);
  endtask

  // One full run; expectations come from truth-table XOR and population count.
  task automatic run_case(input logic [2:0] f, input logic [3:0] phys, input bit hold_start);
    logic [3:0] exp_fail;
    logic [2:0] exp_err;
    logic       exp_pass;
    phys_tt  = phys;
    if (f > 3'd4) begin
      exp_fail = 4'hF;
      exp_err  = 3'd4;
      exp_pass = 1'b0;
    end else begin
      exp_fail = phys ^ exp_tt(f);
      exp_err  = popcnt(exp_fail);
      exp_pass = (exp_fail == 4'h0);
    end
    start    = 1'b1;
    func_sel = f;
    step();
    if (!hold_start) start = 1'b0;
    func_sel = 3'($urandom_range(0, 7));
    if (f > 3'd4) begin
      check("ill.busy", 8'(busy), 8'd0);
      check("ill.done", 8'(done), 8'd1);
    end else begin
      for (int k = 0; k < int'(RUN_CYC); k++) begin
        check("run.busy", 8'(busy), 8'd1);
        check("run.done", 8'(done), 8'd0);
        check("run.stim", 8'({stim_b, stim_a}), 8'(k / int'(S + 1)));
        step();
      end
      check("end.done", 8'(done), 8'd1);
      check("end.busy", 8'(busy), 8'd0);
      check("end.stim", 8'({stim_b, stim_a}), 8'd3);
    end
    check("res.pass", 8'(pass), 8'(exp_pass));
    check("res.fail_vec", 8'(fail_vec), 8'(exp_fail));
    check("res.err_count", 8'(err_count), 8'(exp_err));
    step();
    start = 1'b0;
    check_idle_outputs("post");
    check("post.pass", 8'(pass), 8'(exp_pass));
    check("post.fail_vec", 8'(fail_vec), 8'(exp_fail));
    step();
    check_idle_outputs("post2");
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    func_sel = 3'd0;
    phys_tt  = 4'b1000;
    step();
    step();
    check_idle_outputs("rst");
    check("rst.stim", 8'({stim_b, stim_a}), 8'd0);
    check("rst.pass", 8'(pass), 8'd0);
    check("rst.fail_vec", 8'(fail_vec), 8'd0);
    check("rst.err_count", 8'(err_count), 8'd0);
    rst_n = 1'b1;
    step();

    run_case(3'd0, 4'b1000, 1'b0);  // AND gate, AND expected
    run_case(3'd1, 4'b1000, 1'b0);  // AND gate, NAND expected
    run_case(3'd3, 4'b1110, 1'b0);  // OR gate, XOR expected
    run_case(3'd4, 4'b0101, 1'b0);  // inverter on a
    run_case(3'd4, 4'b1010, 1'b0);  // buffer on a
    run_case(3'd6, 4'b1000, 1'b0);  // illegal select
    run_case(3'd2, 4'b1110, 1'b1);  // start held through the run and done

    // Reset during vector 2 aborts the run.
    phys_tt  = 4'b0000;
    start    = 1'b1;
    func_sel = 3'd1;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(2 * (S + 1) + 1); k++) step();
    check("mid.stim", 8'({stim_b, stim_a}), 8'd2);
    check("mid.busy", 8'(busy), 8'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_idle_outputs("abort");
    check("abort.stim", 8'({stim_b, stim_a}), 8'd0);
    check("abort.pass", 8'(pass), 8'd0);
    check("abort.fail_vec", 8'(fail_vec), 8'd0);
    check("abort.err_count", 8'(err_count), 8'd0);
    step();
    check_idle_outputs("abort2");

    for (int i = 0; i < 24; i++) begin
      run_case(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
